// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard scoreboard: stall and forward selects; mult/div tracking enabled by HAZARD_MDU_EN
module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter int TNEW_W = 2,
    parameter int MD_LAT = 5,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [4:0]        d_wr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_use,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              md_busy
);

    // Entry 0 is E, entry STAGES-1 is W.
    logic              ent_v    [STAGES];
    logic [4:0]        ent_wr   [STAGES];
    logic [TNEW_W-1:0] ent_tnew [STAGES];

    logic              rs_hit;
    logic              rt_hit;
    logic [TNEW_W-1:0] rs_tnew;
    logic [TNEW_W-1:0] rt_tnew;
    logic [SEL_W-1:0]  rs_idx;
    logic [SEL_W-1:0]  rt_idx;
    logic              rs_stall;
    logic              rt_stall;
    logic              md_stall;
    logic              load;

    // Youngest-match search: scan from oldest to youngest so the lowest index wins.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_tnew = '0;
        rt_tnew = '0;
        rs_idx  = '0;
        rt_idx  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (ent_v[k] && (ent_wr[k] == d_rs) && (d_rs != 5'd0)) begin
                rs_hit  = 1'b1;
                rs_tnew = ent_tnew[k];
                rs_idx  = SEL_W'(k + 1);
            end
            if (ent_v[k] && (ent_wr[k] == d_rt) && (d_rt != 5'd0)) begin
                rt_hit  = 1'b1;
                rt_tnew = ent_tnew[k];
                rt_idx  = SEL_W'(k + 1);
            end
        end
    end

    // A source stalls when its youngest producer is not ready by the time it is needed.
    assign rs_stall = d_valid & d_use_rs & rs_hit & (rs_tnew > d_tuse_rs);
    assign rt_stall = d_valid & d_use_rt & rt_hit & (rt_tnew > d_tuse_rt);
    assign stall    = rs_stall | rt_stall | md_stall;

    // Only a ready youngest producer is forwarded; a not-ready one blocks older copies.
    assign fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_idx : '0;
    assign fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_idx : '0;

    assign load = d_valid & ~stall & ~flush;

    // Scoreboard shift: D enters E (or a bubble), older writers age and the W entry retires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ent_v[k]    <= 1'b0;
                ent_wr[k]   <= 5'd0;
                ent_tnew[k] <= '0;
            end
        end else begin
            ent_v[0]    <= load;
            ent_wr[0]   <= load ? d_wr : 5'd0;
            ent_tnew[0] <= load ? d_tnew : '0;
            for (int k = 1; k < STAGES; k++) begin
                ent_v[k]    <= ent_v[k-1];
                ent_wr[k]   <= ent_wr[k-1];
                ent_tnew[k] <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TNEW_W'(1);
            end
        end
    end

`ifdef HAZARD_MDU_EN
    logic [4:0] md_cnt;

    // Mult/div busy counter: reloads on an accepted mult/div, otherwise counts down to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= 5'd0;
        end else if (d_valid & d_md_start & ~stall & ~flush) begin
            md_cnt <= 5'(MD_LAT);
        end else if (md_cnt != 5'd0) begin
            md_cnt <= md_cnt - 5'd1;
        end
    end

    assign md_busy  = (md_cnt != 5'd0);
    assign md_stall = d_valid & (d_md_start | d_md_use) & md_busy;
`else
    logic unused_md;

    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
    assign unused_md = &{1'b0, d_md_start, d_md_use, 5'(MD_LAT)};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard with a history-based reference model
module tb_hazard_scoreboard;

    localparam int STAGES = 3;
    localparam int TNEW_W = 2;
    localparam int MD_LAT = 5;
    localparam int SEL_W  = $clog2(STAGES + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              d_valid;
    logic [4:0]        d_rs;
    logic [4:0]        d_rt;
    logic              d_use_rs;
    logic              d_use_rt;
    logic [TNEW_W-1:0] d_tuse_rs;
    logic [TNEW_W-1:0] d_tuse_rt;
    logic [4:0]        d_wr;
    logic [TNEW_W-1:0] d_tnew;
    logic              d_md_start;
    logic              d_md_use;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              md_busy;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .STAGES(STAGES),
        .TNEW_W(TNEW_W),
        .MD_LAT(MD_LAT),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_valid   (d_valid),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_use_rs  (d_use_rs),
        .d_use_rt  (d_use_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_wr      (d_wr),
        .d_tnew    (d_tnew),
        .d_md_start(d_md_start),
        .d_md_use  (d_md_use),
        .flush     (flush),
        .stall     (stall),
        .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel),
        .md_busy   (md_busy)
    );

    // Reference model: hist[k] is whatever entered E k cycles ago, with the Tnew it entered with.
    typedef struct {
        bit v;
        int wr;
        int tnew0;
    } slot_t;

    slot_t hist[$];
    int    cyc;
    int    md_issue;
    int    n_tests;
    int    n_fail;

    function automatic void model_clear();
        slot_t s;
        s.v = 0; s.wr = 0; s.tnew0 = 0;
        hist.delete();
        for (int i = 0; i < STAGES; i++) hist.push_back(s);
        cyc      = 0;
        md_issue = -1000;
    endfunction

    function automatic int age_tnew(input int k);
        int t;
        t = hist[k].tnew0 - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int lookup(input int r);
        if (r == 0) return -1;
        for (int k = 0; k < STAGES; k++)
            if (hist[k].v && hist[k].wr == r) return k;
        return -1;
    endfunction

    function automatic bit model_busy();
`ifdef HAZARD_MDU_EN
        return (cyc - md_issue >= 1) && (cyc - md_issue <= MD_LAT);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_stall();
        int  k;
        bit  s;
        s = 0;
        k = lookup(int'(d_rs));
        if (d_valid && d_use_rs && k >= 0 && age_tnew(k) > int'(d_tuse_rs)) s = 1;
        k = lookup(int'(d_rt));
        if (d_valid && d_use_rt && k >= 0 && age_tnew(k) > int'(d_tuse_rt)) s = 1;
        if (d_valid && (d_md_start || d_md_use) && model_busy()) s = 1;
        return s;
    endfunction

    function automatic int model_sel(input int r);
        int k;
        k = lookup(r);
        if (k >= 0 && age_tnew(k) == 0) return k + 1;
        return 0;
    endfunction

    // Apply one clock to the model using the current D inputs, then to the DUT.
    task automatic advance();
        slot_t s;
        bit    st;
        bit    iss;
        st    = model_stall();
        iss   = d_valid && !st && !flush;
        s.v     = iss;
        s.wr    = iss ? int'(d_wr) : 0;
        s.tnew0 = iss ? int'(d_tnew) : 0;
`ifdef HAZARD_MDU_EN
        if (iss && d_md_start) md_issue = cyc;
`endif
        hist.push_front(s);
        void'(hist.pop_back());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        d_valid = 0; d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0;
        d_tuse_rs = 0; d_tuse_rt = 0; d_wr = 0; d_tnew = 0;
        d_md_start = 0; d_md_use = 0; flush = 0;
    endtask

    task automatic drive(input bit v, input int rs, input bit urs, input int trs,
                         input int rt, input bit urt, input int trt,
                         input int wr, input int tn);
        set_nop();
        d_valid = v;
        d_rs = 5'(rs); d_use_rs = urs; d_tuse_rs = TNEW_W'(trs);
        d_rt = 5'(rt); d_use_rt = urt; d_tuse_rt = TNEW_W'(trt);
        d_wr = 5'(wr); d_tnew = TNEW_W'(tn);
    endtask

    task automatic drain();
        set_nop();
        for (int i = 0; i < STAGES + 1; i++) advance();
    endtask

    task automatic test_reset();
        reset_n = 0;
        drive(1, 1, 1, 0, 2, 1, 0, 3, 3);
        @(posedge clk);
        #2;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_tests++;
        if (fwd_rs_sel !== '0) begin n_fail++; $display("FAIL reset_fwd_rs: got %0d want 0", fwd_rs_sel); end
        n_tests++;
        if (fwd_rt_sel !== '0) begin n_fail++; $display("FAIL reset_fwd_rt: got %0d want 0", fwd_rt_sel); end
        n_tests++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        set_nop();
        @(posedge clk);
        #1;
        reset_n = 1;
        model_clear();
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0, 0, 0, 2, 2);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_issue_stall: got %b want 0", stall); end
        advance();
        drive(1, 2, 1, 1, 1, 1, 1, 3, 1);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall1: got %b want 1", stall); end
        advance();
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b want 0", stall); end
        n_tests++;
        if (fwd_rs_sel !== 2'd0) begin n_fail++; $display("FAIL load_use_fwd_rs: got %0d want 0", fwd_rs_sel); end
        advance();
        drain();
    endtask

    task automatic test_branch_fwd();
        drive(1, 1, 1, 1, 4, 1, 1, 5, 1);
        advance();
        drive(1, 5, 1, 0, 0, 1, 0, 0, 0);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL beq_stall: got %b want 1", stall); end
        advance();
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL beq_release: got %b want 0", stall); end
        n_tests++;
        if (fwd_rs_sel !== 2'd2) begin n_fail++; $display("FAIL beq_fwd_rs: got %0d want 2", fwd_rs_sel); end
        n_tests++;
        if (fwd_rt_sel !== 2'd0) begin n_fail++; $display("FAIL beq_fwd_rt_r0: got %0d want 0", fwd_rt_sel); end
        advance();
        drain();
    endtask

    task automatic test_youngest_wins();
        drive(1, 0, 0, 0, 0, 0, 0, 7, 1);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 7, 1);
        advance();
        drive(1, 7, 1, 0, 0, 0, 0, 8, 1);
        #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL youngest_stall: got %b want 1", stall); end
        n_tests++;
        if (fwd_rs_sel !== 2'd0) begin n_fail++; $display("FAIL youngest_no_older_fwd: got %0d want 0", fwd_rs_sel); end
        advance();
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL youngest_release: got %b want 0", stall); end
        n_tests++;
        if (fwd_rs_sel !== 2'd2) begin n_fail++; $display("FAIL youngest_fwd_m: got %0d want 2", fwd_rs_sel); end
        advance();
        drain();
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 0, 0, 0, 4, 1);
        flush = 1;
        advance();
        drive(1, 4, 1, 0, 4, 1, 0, 0, 0);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
        n_tests++;
        if (fwd_rs_sel !== 2'd0) begin n_fail++; $display("FAIL flush_fwd_rs: got %0d want 0", fwd_rs_sel); end
        advance();
        drain();
    endtask

    task automatic test_md();
        int cnt;
        bit seen_busy;
        int exp_cnt;
        bit exp_busy;
`ifdef HAZARD_MDU_EN
        exp_cnt  = MD_LAT;
        exp_busy = 1;
`else
        exp_cnt  = 0;
        exp_busy = 0;
`endif
        cnt = 0;
        seen_busy = 0;
        drive(1, 8, 1, 1, 9, 1, 1, 0, 0);
        d_md_start = 1;
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 10, 2);
        d_md_use = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (md_busy) seen_busy = 1;
            if (!stall) break;
            cnt++;
            advance();
        end
        n_tests++;
        if (cnt !== exp_cnt) begin n_fail++; $display("FAIL md_stall_cycles: got %0d want %0d", cnt, exp_cnt); end
        n_tests++;
        if (seen_busy !== exp_busy) begin n_fail++; $display("FAIL md_busy_seen: got %b want %b", seen_busy, exp_busy); end
        n_tests++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_busy_released: got %b want 0", md_busy); end
        advance();
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        d_md_start = 1;
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 2, 0);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0, 3, 3);
        advance();
        drive(1, 3, 1, 0, 2, 1, 0, 6, 1);
        #1;
        n_tests++;
        if (stall !== model_stall()) begin n_fail++; $display("FAIL pre_reset_stall: got %b want %b", stall, model_stall()); end
        reset_n = 0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b want 0", stall); end
        n_tests++;
        if (fwd_rt_sel !== 2'd0) begin n_fail++; $display("FAIL midreset_fwd_rt: got %0d want 0", fwd_rt_sel); end
        n_tests++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_md_busy: got %b want 0", md_busy); end
        @(posedge clk);
        #1;
        reset_n = 1;
        model_clear();
        drive(1, 3, 1, 0, 2, 1, 0, 6, 1);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall: got %b want 0", stall); end
        n_tests++;
        if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL post_reset_fwd: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel);
        end
        advance();
        drain();
    endtask

    task automatic test_random();
        logic [SEL_W-1:0] e_rs;
        logic [SEL_W-1:0] e_rt;
        bit               e_st;
        bit               e_busy;
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 85), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            d_md_start = ($urandom_range(0, 9) == 0);
            d_md_use   = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            #1;
            e_st   = model_stall();
            e_busy = model_busy();
            e_rs   = SEL_W'(model_sel(int'(d_rs)));
            e_rt   = SEL_W'(model_sel(int'(d_rt)));
            n_tests++;
            if (stall !== e_st) begin n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, e_st); end
            n_tests++;
            if (fwd_rs_sel !== e_rs) begin n_fail++; $display("FAIL rand_fwd_rs[%0d]: got %0d want %0d", i, fwd_rs_sel, e_rs); end
            n_tests++;
            if (fwd_rt_sel !== e_rt) begin n_fail++; $display("FAIL rand_fwd_rt[%0d]: got %0d want %0d", i, fwd_rt_sel, e_rt); end
            n_tests++;
            if (md_busy !== e_busy) begin n_fail++; $display("FAIL rand_md_busy[%0d]: got %b want %b", i, md_busy, e_busy); end
            advance();
        end
        drain();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        set_nop();
        model_clear();
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_youngest_wins();
        test_flush();
        test_md();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
